// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and encodings for the ALU share arbiter: word width, ALU opcodes,
// FSM state encodings and the legal-opcode check.
package alu_share_arbiter_pkg;

    localparam int unsigned WORD  = 32;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned N_REQ = 2;

    localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [OP_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // True for the six opcodes the shared ALU implements.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
            default:                                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// Two-way one-hot grant: grants only while idle, favouring the requester
// selected by ptr and falling back to the other one.
module alu_arb_grant (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       idle,
    output logic [1:0] grant_c
);

    always_comb begin
        grant_c = 2'b00;
        if (idle) begin
            if (ptr) begin
                grant_c = valid[1] ? 2'b10 : {1'b0, valid[0]};
            end else begin
                grant_c = valid[0] ? 2'b01 : {valid[1], 1'b0};
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = WORD,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*OP_W-1:0]    req_op,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_zero,
    output logic                     rsp_err,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [OP_W-1:0]          alu_ctrl,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_zero,
    output logic [CNT_W-1:0]         op_count
);

    arb_state_e        state_q, state_d;
    logic              win_q, win_d;
    logic [WIDTH-1:0]  alu_a_d, alu_b_d;
    logic [OP_W-1:0]   alu_ctrl_d;
    logic [N_REQ-1:0]  rsp_valid_d;
    logic [WIDTH-1:0]  rsp_result_d;
    logic              rsp_zero_d, rsp_err_d;
    logic [CNT_W-1:0]  op_count_d;
    logic              idle_c, prio_c, legal_c;
    logic [N_REQ-1:0]  grant_c;

    // Gating with rst_n keeps req_ready low while reset is held.
    assign idle_c    = (state_q == ARB_IDLE) && rst_n;
    assign req_ready = grant_c;
    assign legal_c   = op_is_legal(alu_ctrl);

`ifdef ALU_ARB_RR_EN
    logic prio_q, prio_d;
    assign prio_c = prio_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // After a grant to requester i, requester 1-i is favoured next time.
    always_comb begin
        prio_d = prio_q;
        if (|grant_c) begin
            prio_d = grant_c[0];
        end
    end
`else
    assign prio_c = 1'b0;
`endif

    alu_arb_grant u_grant (
        .valid   (req_valid),
        .ptr     (prio_c),
        .idle    (idle_c),
        .grant_c (grant_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        alu_a_d      = alu_a;
        alu_b_d      = alu_b;
        alu_ctrl_d   = alu_ctrl;
        rsp_valid_d  = rsp_valid;
        rsp_result_d = rsp_result;
        rsp_zero_d   = rsp_zero;
        rsp_err_d    = rsp_err;
        op_count_d   = op_count;

        case (state_q)
            ARB_IDLE: begin
                if (|grant_c) begin
                    win_d      = grant_c[1];
                    alu_ctrl_d = grant_c[1] ? req_op[2*OP_W-1:OP_W]   : req_op[OP_W-1:0];
                    alu_a_d    = grant_c[1] ? req_a[2*WIDTH-1:WIDTH]  : req_a[WIDTH-1:0];
                    alu_b_d    = grant_c[1] ? req_b[2*WIDTH-1:WIDTH]  : req_b[WIDTH-1:0];
                    state_d    = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                // An illegal opcode never exposes whatever the ALU produced.
                rsp_result_d = legal_c ? alu_result : '0;
                rsp_zero_d   = legal_c & alu_zero;
                rsp_err_d    = ~legal_c;
                rsp_valid_d  = win_q ? 2'b10 : 2'b01;
                state_d      = ARB_RESP;
            end
            ARB_RESP: begin
                if (rsp_ready[win_q]) begin
                    rsp_valid_d = '0;
                    op_count_d  = (&op_count) ? op_count : op_count + CNT_W'(1);
                    state_d     = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            win_q      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            alu_ctrl   <= alu_ctrl_d;
            rsp_valid  <= rsp_valid_d;
            rsp_result <= rsp_result_d;
            rsp_zero   <= rsp_zero_d;
            rsp_err    <= rsp_err_d;
            op_count   <= op_count_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU on the alu_* ports.
// Honours ALU_ARB_RR_EN when checking grant order.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0]      req_op;
    logic [2*W-1:0]  req_a, req_b;
    logic [W-1:0]    rsp_result, alu_a, alu_b, alu_result;
    logic            rsp_zero, rsp_err, alu_zero;
    logic [3:0]      alu_ctrl;
    logic [CW-1:0]   op_count;

    typedef struct {
        logic         idx;
        logic [W-1:0] res;
        logic         zero;
        logic         err;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [CW-1:0] exp_count = '0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .op_count(op_count)
    );

    // Stand-in for the external ALU; unknown opcodes yield a non-zero marker.
    always_comb begin
        case (alu_ctrl)
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            ALU_NOR: alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'h1234_5678;
        endcase
        alu_zero = (alu_result == '0);
    end

    function automatic exp_t ref_op(input logic idx, input logic [3:0] op,
                                    input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.idx = idx;
        e.err = 1'b0;
        if      (op == ALU_ADD) e.res = a + b;
        else if (op == ALU_SUB) e.res = a - b;
        else if (op == ALU_AND) e.res = a & b;
        else if (op == ALU_OR)  e.res = a | b;
        else if (op == ALU_NOR) e.res = ~(a | b);
        else if (op == ALU_SLT) e.res = {31'd0, $signed(a) < $signed(b)};
        else begin
            e.res = '0;
            e.err = 1'b1;
        end
        e.zero = !e.err && (e.res == '0);
        return e;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == {CW{1'b1}}) ? c : c + 1'b1;
    endfunction

    task automatic drive_req(input int idx, input logic [3:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[4*idx +: 4] = op;
        req_a[W*idx +: W]  = a;
        req_b[W*idx +: W]  = b;
    endtask

    // One complete transaction on requester idx; hold > 0 stalls the response.
    task automatic do_op(input int idx, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold, input string tag);
        exp_t       e;
        int         waited;
        logic [1:0] oh;
        oh = (idx == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        drive_req(idx, op, a, b);
        req_valid = oh;
        rsp_ready = (hold > 0) ? 2'b00 : 2'b11;
        #1;
        waited = 0;
        while (req_ready !== oh && waited < 8) begin
            @(negedge clk); #1; waited++;
        end
        n_cmp++;
        if (req_ready !== oh) begin
            $display("FAIL %s grant: req_ready=%b required %b", tag, req_ready, oh);
            n_bad++;
            req_valid = '0;
            return;
        end
        sb.push_back(ref_op(idx[0], op, a, b));
        @(negedge clk);
        req_valid = '0;
        waited = 0;
        while (rsp_valid == 2'b00 && waited < 8) begin
            @(negedge clk); waited++;
        end
        n_cmp++;
        if (waited !== 1) begin
            $display("FAIL %s latency: response after %0d cycles in EXEC, required 1", tag, waited);
            n_bad++;
        end
        e = sb.pop_front();
        n_cmp++;
        if ({rsp_valid, rsp_result, rsp_zero, rsp_err} !== {oh, e.res, e.zero, e.err}) begin
            $display("FAIL %s response: valid=%b result=%h zero=%b err=%b required valid=%b result=%h zero=%b err=%b",
                     tag, rsp_valid, rsp_result, rsp_zero, rsp_err, oh, e.res, e.zero, e.err);
            n_bad++;
        end
        for (int k = 0; k < hold; k++) begin
            rsp_ready = ~oh;
            req_valid = ~oh;
            @(negedge clk); #1;
            n_cmp++;
            if (rsp_valid !== oh || rsp_result !== e.res || req_ready !== 2'b00) begin
                $display("FAIL %s hold%0d: valid=%b result=%h req_ready=%b required valid=%b result=%h req_ready=00",
                         tag, k, rsp_valid, rsp_result, req_ready, oh, e.res);
                n_bad++;
            end
        end
        req_valid = '0;
        rsp_ready = 2'b11;
        @(negedge clk);
        exp_count = sat_inc(exp_count);
        n_cmp++;
        if (rsp_valid !== 2'b00 || op_count !== exp_count) begin
            $display("FAIL %s complete: valid=%b op_count=%0d required valid=00 op_count=%0d",
                     tag, rsp_valid, op_count, exp_count);
            n_bad++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_ctrl, op_count} !== '0) begin
            $display("FAIL reset_outputs: ready=%b valid=%b result=%h zero=%b err=%b a=%h b=%h ctrl=%h count=%0d required all zero",
                     req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_ctrl, op_count);
            n_bad++;
        end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = '0;
    endtask

    task automatic test_add();
        do_op(0, ALU_ADD, 32'd5, 32'd1, 0, "add_r0");
    endtask

    task automatic test_sub();
        do_op(1, ALU_SUB, 32'd5, 32'd5, 0, "sub_r1_zero");
    endtask

    task automatic test_hold();
        do_op(0, ALU_SLT, 32'd1, 32'd5, 3, "slt_hold");
    endtask

    task automatic test_illegal();
        do_op(0, 4'hF, 32'd7, 32'd3, 0, "illegal_op");
    endtask

    task automatic test_ops();
        do_op(1, ALU_AND, 32'h0000_00F0, 32'h0000_000F, 0, "and_r1");
        do_op(0, ALU_OR,  32'hA000_0000, 32'h0000_0005, 0, "or_r0");
        do_op(1, ALU_NOR, 32'd0, 32'd0, 0, "nor_r1");
        do_op(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0, "slt_neg");
    endtask

    task automatic test_withdraw();
        @(negedge clk);
        drive_req(0, ALU_ADD, 32'd9, 32'd9);
        req_valid = 2'b01;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            $display("FAIL withdraw_grant: req_ready=%b required 01", req_ready);
            n_bad++;
        end
        #1 req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 2'b00 || op_count !== exp_count) begin
                $display("FAIL withdraw_idle%0d: valid=%b op_count=%0d required valid=00 op_count=%0d",
                         k, rsp_valid, op_count, exp_count);
                n_bad++;
            end
        end
    endtask

    // Both requesters continuously valid for four operations from a fresh reset.
    task automatic test_arb();
        int         g, r, cyc, exp_idx;
        logic [1:0] exp_oh;
        exp_t       e;
        test_reset();
        g = 0; r = 0; cyc = 0;
        drive_req(0, ALU_ADD, 32'd10, 32'd3);
        drive_req(1, ALU_SUB, 32'd10, 32'd3);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        while ((g < 4 || r < 4) && cyc < 60) begin
            if (g == 4) req_valid = 2'b00;
            #1;
            if (req_ready != 2'b00 && g < 4) begin
`ifdef ALU_ARB_RR_EN
                exp_idx = g % 2;
`else
                exp_idx = 0;
`endif
                exp_oh = (exp_idx == 1) ? 2'b10 : 2'b01;
                n_cmp++;
                if (req_ready !== exp_oh) begin
                    $display("FAIL arb_grant%0d: req_ready=%b required %b", g, req_ready, exp_oh);
                    n_bad++;
                end
                sb.push_back(ref_op(req_ready[1], req_ready[1] ? ALU_SUB : ALU_ADD, 32'd10, 32'd3));
                g++;
            end
            if (rsp_valid != 2'b00) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    $display("FAIL arb_rsp%0d: unexpected response valid=%b", r, rsp_valid);
                    n_bad++;
                end else begin
                    e = sb.pop_front();
                    if ({rsp_valid, rsp_result, rsp_zero, rsp_err} !== {e.idx ? 2'b10 : 2'b01, e.res, e.zero, e.err}) begin
                        $display("FAIL arb_rsp%0d: valid=%b result=%h zero=%b err=%b required idx=%0d result=%h zero=%b err=%b",
                                 r, rsp_valid, rsp_result, rsp_zero, rsp_err, e.idx, e.res, e.zero, e.err);
                        n_bad++;
                    end
                end
                exp_count = sat_inc(exp_count);
                r++;
            end
            cyc++;
            @(negedge clk);
        end
        req_valid = 2'b00;
        n_cmp++;
        if (g !== 4 || r !== 4 || op_count !== exp_count) begin
            $display("FAIL arb_done: grants=%0d responses=%0d op_count=%0d required 4/4/%0d",
                     g, r, op_count, exp_count);
            n_bad++;
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 5; k++) begin
            do_op(k % 2, ALU_ADD, W'(k), 32'd100, 0, "saturate");
        end
        n_cmp++;
        if (op_count !== 3'b111) begin
            $display("FAIL saturate_final: op_count=%0d required 7", op_count);
            n_bad++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_req(0, ALU_ADD, 32'd2, 32'd2);
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        @(negedge clk);
        req_valid = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_ctrl, op_count} !== '0) begin
            $display("FAIL reset_mid_outputs: ready=%b valid=%b result=%h a=%h b=%h ctrl=%h count=%0d required all zero",
                     req_ready, rsp_valid, rsp_result, alu_a, alu_b, alu_ctrl, op_count);
            n_bad++;
        end
        exp_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 2'b00 || op_count !== exp_count) begin
                $display("FAIL reset_mid_quiet%0d: valid=%b op_count=%0d required 00/%0d",
                         k, rsp_valid, op_count, exp_count);
                n_bad++;
            end
        end
        drive_req(1, ALU_SUB, 32'd4, 32'd1);
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            $display("FAIL reset_mid_prio: req_ready=%b required 01", req_ready);
            n_bad++;
        end
        req_valid = 2'b00;
        do_op(0, ALU_ADD, 32'd2, 32'd2, 0, "after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        test_reset();
        test_add();
        test_sub();
        test_hold();
        test_illegal();
        test_ops();
        test_withdraw();
        test_arb();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
